// File: rtl/hex_display_pkg.sv
// Shared constants and mode encodings for the seven-segment hex display driver.
package hex_display_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ALL   = 7'b0000000;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_LZ     = 2'b01,
        MODE_LAMP   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

endpackage

// File: rtl/hex_display_driver_if.sv
// Data/control bundle between a value source and the hex display driver.
interface hex_display_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [1:0]            mode;
    logic [DIGITS-1:0]     blink_mask;
    logic [7*DIGITS-1:0]   seg;
    logic                  updated;

    modport master (
        output load, value, mode, blink_mask,
        input  seg, updated
    );

    modport slave (
        input  load, value, mode, blink_mask,
        output seg, updated
    );
endinterface

// File: rtl/hex_glyph.sv
// Combinational nibble to active-low abcdefg glyph decode (bit 6 = a, 0 = lit).
module hex_glyph
    import hex_display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Glyph lookup table.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: value capture, leading-zero blanking, lamp test,
// display-off and per-digit blinking, with registered active-low segment outputs.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_display_driver_if.slave  bus
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0]     value_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    phase_r;
    logic                    load_d_r;
    logic                    updated_r;
    logic [SEG_W*DIGITS-1:0] seg_r;
    logic [SEG_W*DIGITS-1:0] seg_s;
    logic [SEG_W*DIGITS-1:0] glyph_s;
    logic [DIGITS-1:0]       lz_s;
    mode_e                   mode_s;

    assign mode_s      = mode_e'(bus.mode);
    assign bus.seg     = seg_r;
    assign bus.updated = updated_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        hex_glyph u_glyph (
            .nibble (value_r[4*g +: 4]),
            .seg    (glyph_s[SEG_W*g +: SEG_W])
        );
    end

    // Leading-zero chain: lz_s[k] set when nibbles DIGITS-1 down to k are all zero.
    always_comb begin
        lz_s = '0;
        lz_s[DIGITS-1] = (value_r[4*(DIGITS-1) +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lz_s[k] = lz_s[k+1] && (value_r[4*k +: 4] == 4'h0);
        end
    end

    // Per-digit priority: off, lamp test, blink blank, leading-zero blank, glyph.
    always_comb begin
        seg_s = {DIGITS{SEG_BLANK}};
        for (int k = 0; k < DIGITS; k++) begin
            case (mode_s)
                MODE_OFF:  seg_s[SEG_W*k +: SEG_W] = SEG_BLANK;
                MODE_LAMP: seg_s[SEG_W*k +: SEG_W] = SEG_ALL;
                MODE_LZ: begin
                    if (bus.blink_mask[k] && phase_r) begin
                        seg_s[SEG_W*k +: SEG_W] = SEG_BLANK;
                    end else if ((k != 0) && lz_s[k]) begin
                        seg_s[SEG_W*k +: SEG_W] = SEG_BLANK;
                    end else begin
                        seg_s[SEG_W*k +: SEG_W] = glyph_s[SEG_W*k +: SEG_W];
                    end
                end
                MODE_NORMAL: begin
                    if (bus.blink_mask[k] && phase_r) begin
                        seg_s[SEG_W*k +: SEG_W] = SEG_BLANK;
                    end else begin
                        seg_s[SEG_W*k +: SEG_W] = glyph_s[SEG_W*k +: SEG_W];
                    end
                end
                default:   seg_s[SEG_W*k +: SEG_W] = SEG_BLANK;
            endcase
        end
    end

    // Value capture, free-running blink divider, output and updated pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r   <= '0;
            cnt_r     <= '0;
            phase_r   <= 1'b0;
            load_d_r  <= 1'b0;
            updated_r <= 1'b0;
            seg_r     <= {DIGITS{SEG_BLANK}};
        end else begin
            if (bus.load) begin
                value_r <= bus.value;
            end
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
            // updated trails load by two edges so it coincides with the new seg value.
            load_d_r  <= bus.load;
            updated_r <= load_d_r;
            seg_r     <= seg_s;
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed self-checking bench for hex_display_driver (DIGITS=4, BLINK_DIV=4).
module tb_hex_display_driver;

    localparam logic [6:0] G_0 = 7'b0000001;
    localparam logic [6:0] G_1 = 7'b1001111;
    localparam logic [6:0] G_2 = 7'b0010010;
    localparam logic [6:0] G_3 = 7'b0000110;
    localparam logic [6:0] G_4 = 7'b1001100;
    localparam logic [6:0] G_5 = 7'b0100100;
    localparam logic [6:0] G_6 = 7'b0100000;
    localparam logic [6:0] G_7 = 7'b0001111;
    localparam logic [6:0] G_8 = 7'b0000000;
    localparam logic [6:0] G_9 = 7'b0001100;
    localparam logic [6:0] G_A = 7'b0001000;
    localparam logic [6:0] G_B = 7'b1100000;
    localparam logic [6:0] G_C = 7'b0110001;
    localparam logic [6:0] G_D = 7'b1000010;
    localparam logic [6:0] G_E = 7'b0110000;
    localparam logic [6:0] G_F = 7'b0111000;
    localparam logic [6:0] BL  = 7'b1111111;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    hex_display_driver_if #(.DIGITS(4)) bus ();

    hex_display_driver #(
        .DIGITS    (4),
        .BLINK_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset with load held so the first edge after release captures v.
    task automatic reset_and_load(input logic [15:0] v, input logic [1:0] m, input logic [3:0] mask);
        @(negedge clk);
        rst = 1'b1; bus.load = 1'b1; bus.value = v; bus.mode = m; bus.blink_mask = mask;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF; bus.mode = 2'b00; bus.blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.seg !== 28'hFFFFFFF) begin fails++; $display("FAIL reset_seg: got %h want %h", bus.seg, 28'hFFFFFFF); end
        tests++;
        if (bus.updated !== 1'b0) begin fails++; $display("FAIL reset_updated: got %b want 0", bus.updated); end
        bus.load = 1'b0; rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.seg !== {G_0, G_0, G_0, G_0}) begin fails++; $display("FAIL reset_release_seg: got %h want %h", bus.seg, {G_0, G_0, G_0, G_0}); end
    endtask

    task automatic test_load();
        logic [15:0] vals [3];
        logic [27:0] exps [3];
        vals[0] = 16'h1A3F; exps[0] = {G_1, G_A, G_3, G_F};
        vals[1] = 16'h5C6E; exps[1] = {G_5, G_C, G_6, G_E};
        vals[2] = 16'h27BD; exps[2] = {G_2, G_7, G_B, G_D};
        bus.mode = 2'b00; bus.blink_mask = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.load = 1'b1; bus.value = vals[n];
            @(negedge clk);
            bus.load = 1'b0;
            tests++;
            if (bus.updated !== 1'b0) begin fails++; $display("FAIL load_updated_early[%0d]: got %b want 0", n, bus.updated); end
            @(negedge clk);
            tests++;
            if (bus.seg !== exps[n]) begin fails++; $display("FAIL load_seg[%0d]: got %h want %h", n, bus.seg, exps[n]); end
            tests++;
            if (bus.updated !== 1'b1) begin fails++; $display("FAIL load_updated_pulse[%0d]: got %b want 1", n, bus.updated); end
            @(negedge clk);
            tests++;
            if (bus.updated !== 1'b0) begin fails++; $display("FAIL load_updated_late[%0d]: got %b want 0", n, bus.updated); end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [4];
        logic [1:0]  modes [4];
        logic [27:0] exps [4];
        vals[0] = 16'h0040; modes[0] = 2'b01; exps[0] = {BL, BL, G_4, G_0};
        vals[1] = 16'h0000; modes[1] = 2'b01; exps[1] = {BL, BL, BL, G_0};
        vals[2] = 16'h0F00; modes[2] = 2'b01; exps[2] = {BL, G_F, G_0, G_0};
        vals[3] = 16'h0040; modes[3] = 2'b00; exps[3] = {G_0, G_0, G_4, G_0};
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            bus.load = 1'b1; bus.value = vals[n]; bus.mode = modes[n];
            @(negedge clk);
            bus.load = 1'b0;
            @(negedge clk);
            tests++;
            if (bus.seg !== exps[n]) begin fails++; $display("FAIL lz_seg[%0d]: got %h want %h", n, bus.seg, exps[n]); end
        end
    endtask

    task automatic test_blink();
        logic [27:0] exp_seg;
        logic [6:0]  d0;
        reset_and_load(16'h8888, 2'b00, 4'b0001);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) begin
                exp_seg = {G_0, G_0, G_0, G_0};
            end else begin
                if ((((i - 1) / 4) % 2) == 1) d0 = BL;
                else if (i >= 9)             d0 = G_9;
                else                         d0 = G_8;
                exp_seg = {G_8, G_8, G_8, d0};
            end
            tests++;
            if (bus.seg !== exp_seg) begin fails++; $display("FAIL blink_seg[edge %0d]: got %h want %h", i, bus.seg, exp_seg); end
            if (i == 8) begin
                tests++;
                if (bus.updated !== 1'b1) begin fails++; $display("FAIL blink_updated: got %b want 1", bus.updated); end
            end
            if (i == 1) bus.load = 1'b0;
            if (i == 6) begin bus.load = 1'b1; bus.value = 16'h8889; end
            if (i == 7) bus.load = 1'b0;
        end
    endtask

    task automatic test_lamp_off();
        reset_and_load(16'h8888, 2'b00, 4'b0001);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) bus.load = 1'b0;
            if (i == 5) begin
                tests++;
                if (bus.seg !== 28'h0000000) begin fails++; $display("FAIL lamp_seg: got %h want %h", bus.seg, 28'h0000000); end
            end
            if (i == 6) begin
                tests++;
                if (bus.seg !== 28'hFFFFFFF) begin fails++; $display("FAIL off_seg: got %h want %h", bus.seg, 28'hFFFFFFF); end
            end
            if (i == 7) begin
                tests++;
                if (bus.seg !== {G_8, G_8, G_8, G_8}) begin fails++; $display("FAIL normal_return_seg: got %h want %h", bus.seg, {G_8, G_8, G_8, G_8}); end
            end
            if (i == 8) begin
                tests++;
                if (bus.seg !== 28'hFFFFFFF) begin fails++; $display("FAIL blink_all_seg: got %h want %h", bus.seg, 28'hFFFFFFF); end
            end
            if (i == 4) begin bus.mode = 2'b10; bus.blink_mask = 4'b1111; end
            if (i == 5) bus.mode = 2'b11;
            if (i == 6) begin bus.mode = 2'b00; bus.blink_mask = 4'b0000; end
            if (i == 7) bus.blink_mask = 4'b1111;
        end
    endtask

    task automatic test_async_reset();
        logic [27:0] exp_seg;
        reset_and_load(16'h8888, 2'b00, 4'b0001);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) bus.load = 1'b0;
            if (i == 5) begin bus.load = 1'b1; bus.value = 16'h8889; end
            if (i == 6) bus.load = 1'b0;
        end
        tests++;
        if (bus.seg !== {G_8, G_8, G_8, BL}) begin fails++; $display("FAIL pre_reset_seg: got %h want %h", bus.seg, {G_8, G_8, G_8, BL}); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.seg !== 28'hFFFFFFF) begin fails++; $display("FAIL async_reset_seg: got %h want %h", bus.seg, 28'hFFFFFFF); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp_seg = (i == 5) ? {G_0, G_0, G_0, BL} : {G_0, G_0, G_0, G_0};
            tests++;
            if (bus.seg !== exp_seg) begin fails++; $display("FAIL post_reset_blink[edge %0d]: got %h want %h", i, bus.seg, exp_seg); end
            if (i <= 2) begin
                tests++;
                if (bus.updated !== 1'b0) begin fails++; $display("FAIL post_reset_updated[edge %0d]: got %b want 0", i, bus.updated); end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_load();
        test_lz();
        test_blink();
        test_lamp_off();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised multi-digit hexadecimal display driver for the board's seven-segment banks. It captures a DIGITS-wide hex value on a load strobe and decodes each nibble to an active-low abcdefg pattern. It adds runtime-selectable leading-zero blanking, lamp test, display-off and per-digit blinking from an internal divider. It sits between any datapath result register and the HEX pins and replaces per-digit decoder instances at the top level.

## Interface
- DIGITS, 4, number of digits driven (1..8)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (minimum 2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture `value` this cycle
- value  in  4*DIGITS  hex value; nibble k drives digit k (digit 0 = least significant)
- mode  in  2  00 normal, 01 leading-zero blank, 10 lamp test, 11 off
- blink_mask  in  DIGITS  bit k set: digit k blinks
- seg  out  7*DIGITS  registered segments; digit k at [7k+6:7k], bit 6 = a … bit 0 = g, 0 = lit
- updated  out  1  one-cycle pulse: captured value now visible on `seg`

## Operation
- The value register captures `value` on any cycle with `load` = 1. It holds otherwise. `load` held high captures every cycle.
- Glyphs (abcdefg) are as follows:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Blank = 1111111.
- `mode` and `blink_mask` are sampled every cycle and are not latched by `load`.
- Priority per digit, highest first:
  1. off → blank
  2. lamp test → 0000000
  3. blink blank (mask bit set and phase = 1) → blank
  4. leading-zero blank (mode 01) → blank
  5. otherwise → glyph
- Leading-zero rule:
  - Digit k (k ≥ 1) is blanked iff nibbles DIGITS-1 down to k are all zero.
  - Digit 0 is never LZ-blanked, so value 0 shows a single "0".
- Blink divider:
  - Counter of width $clog2(BLINK_DIV) counts 0..BLINK_DIV-1 and wraps.
  - `phase` toggles on the wrap cycle. Phase 0 = visible.
  - The divider free-runs regardless of mode, mask or load; `load` does not restart it.

## Timing
- Reset (asynchronous, immediate):
  - value register = 0, counter = 0, phase = 0
  - seg = all ones (every digit blank)
  - updated = 0
- First edge after reset release: seg shows the decode of value 0 under the current mode.
- Load latency:
  - `load` at edge N → value register updates at N.
  - `seg` reflects it at N+1 and `updated` = 1 during the cycle following N+1 only.
- Mode/mask latency: one cycle, since `seg` is registered from the current inputs.
- Blink:
  - Full period = 2·BLINK_DIV cycles.
  - Visibility changes one cycle after the phase toggle.
- Simultaneous events:
  - load during blink-blank: the value is captured and shows when phase returns to 0. `updated` still pulses.
  - Mode change during `updated`: no interaction.
- Reset mid-operation discards any pending `updated` pulse and the blink state.

## Structure
- Package `hex_display_pkg`:
  - SEG_W = 7, SEG_BLANK = 7'b1111111, SEG_ALL = 7'b0000000
  - mode encodings MODE_NORMAL/MODE_LZ/MODE_LAMP/MODE_OFF
- Sub-module `hex_glyph`: combinational 4-bit → 7-bit decode, instantiated DIGITS times via generate. The glyph table lives only here.
- Top level holds: value register, leading-zero prefix chain (MSB downward), blink divider, per-digit priority mux, output register, `updated` delay pipe.

## Test plan
Run with DIGITS=4, BLINK_DIV=4.
- Reset: hold rst with load=1, value=16'hFFFF → seg=28'hFFFFFFF, updated=0. Release with mode 00 → all digits 0000001 after one edge.
- Load 16'h1A3F, mode 00 → two cycles later, digits 3..0 = 1001111, 0001000, 0000110, 0111000. `updated` high exactly one cycle.
- Mode 01 with 16'h0040 → digits 3,2 = 1111111, digit 1 = 1001100, digit 0 = 0000001. Load 16'h0000 → only digit 0 lit (0000001).
- blink_mask=4'b0001, value 16'h8888 → digit 0 alternates 0000000 (4 cycles) / 1111111 (4 cycles), period 8. Digits 1–3 stay 0000000. Load mid-blank does not shift phase.
- Mode 10 with blink_mask=4'b1111 and phase 1 → all digits 0000000. Mode 11 → all 1111111. Back to mode 00 → glyphs return next cycle.
- Assert rst asynchronously mid-blink, between edges → seg goes all-ones without a clock edge. After release, the blink phase restarts visible and counts 4 cycles before the first blank.
